// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and helpers for the MIPS front-end pipeline
package mips_pkg;

  localparam int WORD = 32;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // sll $0,$0,0
  localparam logic [WORD-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // A redirect squashes whatever is stalled, since that instruction is on the wrong path.
  function automatic logic [1:0] next_state(input logic branch_taken, input logic stall);
    if (branch_taken) return ST_FLUSH;
    if (stall)        return ST_STALL;
    return ST_RUN;
  endfunction

endpackage

// File: rtl/if_id_pipe_ctrl_if.sv
// rtl/if_id_pipe_ctrl_if.sv - fetch/decode control bundle between hazard/branch logic and the PC + IF/ID stage
interface if_id_pipe_ctrl_if;
  import mips_pkg::*;

  logic            Stall;
  logic            BranchTaken;
  logic [WORD-1:0] BranchTarget;
  logic [WORD-1:0] Instr_IF;
  logic [WORD-1:0] PC_IF;
  logic [WORD-1:0] Instr_ID;
  logic [WORD-1:0] PCPlus4_ID;
  logic            Valid_ID;
  logic            Bubble_EX;
  logic [1:0]      State;
  logic            StallTimeout;

  modport master (
    output Stall, BranchTaken, BranchTarget, Instr_IF,
    input  PC_IF, Instr_ID, PCPlus4_ID, Valid_ID, Bubble_EX, State, StallTimeout
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, Instr_IF,
    output PC_IF, Instr_ID, PCPlus4_ID, Valid_ID, Bubble_EX, State, StallTimeout
  );

endinterface

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - saturating consecutive-stall counter with a sticky timeout flag
module stall_watchdog #(
  parameter int MAX_STALL = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic stall_state_i,
  output logic timeout_o
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_STALL);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // Counts cycles that end in STALL, so the flag rises on the edge of the MAX_STALL-th stall.
  always_comb begin
    cnt_d = 8'd0;
    if (stall_state_i) begin
      cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 8'd1;
    end
    timeout_d = timeout_q | (cnt_d == MAX_CNT);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/if_id_pipe_ctrl.sv
// rtl/if_id_pipe_ctrl.sv - PC register and IF/ID pipeline register with stall/flush control
module if_id_pipe_ctrl
  import mips_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int              MAX_STALL = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  if_id_pipe_ctrl_if.slave   bus
);

  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0] pcplus4_q, pcplus4_d;
  logic            valid_q, valid_d;
  logic [1:0]      state_q, state_d;
  logic [WORD-1:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    state_d   = next_state(bus.BranchTaken, bus.Stall);
    if (bus.BranchTaken) begin
      pc_d      = bus.BranchTarget & ~32'h3;
      instr_d   = NOP_INSTR;
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (!bus.Stall) begin
      pc_d      = pc_plus4;
      instr_d   = bus.Instr_IF;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
      state_q   <= ST_RUN;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
      state_q   <= state_d;
    end
  end

  stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_stall_watchdog (
    .Clk           (Clk),
    .Reset         (Reset),
    .stall_state_i (state_d == ST_STALL),
    .timeout_o     (bus.StallTimeout)
  );

  assign bus.PC_IF      = pc_q;
  assign bus.Instr_ID   = instr_q;
  assign bus.PCPlus4_ID = pcplus4_q;
  assign bus.Valid_ID   = valid_q;
  assign bus.State      = state_q;
  assign bus.Bubble_EX  = Reset & (bus.Stall | bus.BranchTaken | ~valid_q);

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// tb/tb_if_id_pipe_ctrl.sv - directed self-checking bench for if_id_pipe_ctrl
module tb_if_id_pipe_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  if_id_pipe_ctrl_if bus_if();

  if_id_pipe_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000),
    .MAX_STALL (16)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: word at address a reads as a ^ 32'h1234_0000.
  assign bus_if.Instr_IF = bus_if.PC_IF ^ 32'h1234_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] p4, input logic v, input logic [1:0] st);
    chk({tag, ".pc"},    bus_if.PC_IF,      pc);
    chk({tag, ".instr"}, bus_if.Instr_ID,   ins);
    chk({tag, ".pc4"},   bus_if.PCPlus4_ID, p4);
    chk({tag, ".valid"}, {31'd0, bus_if.Valid_ID}, {31'd0, v});
    chk({tag, ".state"}, {30'd0, bus_if.State},    {30'd0, st});
  endtask

  initial begin
    Reset               = 1'b0;
    bus_if.Stall        = 1'b1;
    bus_if.BranchTaken  = 1'b1;
    bus_if.BranchTarget = 32'h0000_0F00;
    tick();
    tick();
    // reset ignores stall/branch and keeps bubble low
    chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
    chk("rst.to",     {31'd0, bus_if.StallTimeout}, 32'd0);
    chk("rst.bubble", {31'd0, bus_if.Bubble_EX},    32'd0);

    Reset              = 1'b1;
    bus_if.Stall       = 1'b0;
    bus_if.BranchTaken = 1'b0;
    #1 chk("t1.bubble0", {31'd0, bus_if.Bubble_EX}, 32'd1);
    tick(); chk_if("t1.c1", 32'h4, 32'h1234_0000, 32'h4, 1'b1, 2'd0);
    chk("t1.bubble1", {31'd0, bus_if.Bubble_EX}, 32'd0);
    tick(); chk_if("t1.c2", 32'h8, 32'h1234_0004, 32'h8, 1'b1, 2'd0);

    // single stall at PC=8
    bus_if.Stall = 1'b1;
    #1 chk("t2.bubble", {31'd0, bus_if.Bubble_EX}, 32'd1);
    tick(); chk_if("t2.hold", 32'h8, 32'h1234_0004, 32'h8, 1'b1, 2'd1);
    bus_if.Stall = 1'b0;
    tick(); chk_if("t2.resume", 32'hC, 32'h1234_0008, 32'hC, 1'b1, 2'd0);
    tick(); chk_if("t2.adv", 32'h10, 32'h1234_000C, 32'h10, 1'b1, 2'd0);

    // branch; low target bits must be dropped
    bus_if.BranchTaken  = 1'b1;
    bus_if.BranchTarget = 32'h0000_0043;
    #1 chk("t3.bubble", {31'd0, bus_if.Bubble_EX}, 32'd1);
    tick(); chk_if("t3.flush", 32'h40, 32'h0, 32'h0, 1'b0, 2'd2);
    bus_if.BranchTaken = 1'b0;
    #1 chk("t3.bubble2", {31'd0, bus_if.Bubble_EX}, 32'd1);
    tick(); chk_if("t3.load", 32'h44, 32'h1234_0040, 32'h44, 1'b1, 2'd0);

    // stall + branch: branch wins; then a back-to-back branch
    bus_if.Stall        = 1'b1;
    bus_if.BranchTaken  = 1'b1;
    bus_if.BranchTarget = 32'h0000_0080;
    tick(); chk_if("t4.win", 32'h80, 32'h0, 32'h0, 1'b0, 2'd2);
    bus_if.Stall        = 1'b0;
    bus_if.BranchTarget = 32'h0000_0100;
    tick(); chk_if("t4.b2b", 32'h100, 32'h0, 32'h0, 1'b0, 2'd2);
    bus_if.BranchTaken = 1'b0;
    tick(); chk_if("t4.load", 32'h104, 32'h1234_0100, 32'h104, 1'b1, 2'd0);

    // adder wrap
    bus_if.BranchTaken  = 1'b1;
    bus_if.BranchTarget = 32'hFFFF_FFFC;
    tick(); chk("wrap.pc0", bus_if.PC_IF, 32'hFFFF_FFFC);
    bus_if.BranchTaken = 1'b0;
    tick(); chk_if("wrap", 32'h0, 32'hEDCB_FFFC, 32'h0, 1'b1, 2'd0);

    for (int i = 0; i < 8; i++) tick();
    chk("adv.pc20", bus_if.PC_IF, 32'h20);

    // watchdog: 15 stalls quiet, 16th sets the flag
    bus_if.Stall = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("t5.to15", {31'd0, bus_if.StallTimeout}, 32'd0);
    chk_if("t5.hold", 32'h20, 32'h1234_001C, 32'h20, 1'b1, 2'd1);
    tick(); chk("t5.to16", {31'd0, bus_if.StallTimeout}, 32'd1);
    tick(); chk("t5.to17", {31'd0, bus_if.StallTimeout}, 32'd1);

    // reset mid-stall at PC=0x20
    Reset = 1'b0;
    tick();
    chk_if("t6.rst", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
    chk("t6.to", {31'd0, bus_if.StallTimeout}, 32'd0);

    // counter restarted from zero: 15 stalls must not trip it
    Reset = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("t6.cnt15", {31'd0, bus_if.StallTimeout}, 32'd0);
    chk("t6.pc", bus_if.PC_IF, 32'h0);
    tick(); chk("t6.cnt16", {31'd0, bus_if.StallTimeout}, 32'd1);
    bus_if.Stall = 1'b0;
    tick(); chk("t5.sticky", {31'd0, bus_if.StallTimeout}, 32'd1);
    chk_if("t5.run", 32'h4, 32'h1234_0000, 32'h4, 1'b1, 2'd0);
    tick(); chk("t5.sticky2", {31'd0, bus_if.StallTimeout}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
